csr_file: RTL and testbench

Parametrised machine-mode CSR file for the OTTER MCU. It replaces the fixed three-register CSR block.
- Adds CSRRW/CSRRS/CSRRC read-modify-write, mstatus MIE/MPIE stacking with MRET, and multiple prioritised level-sensitive interrupt lines.
- Adds mcause, optional vectored mtvec, and free-running mcycle/minstret counters.
- Sits beside the register file. Read in decode/execute, written at writeback; the control FSM uses INT_PEND/TRAP_PC.

---
 rtl/csr_pkg.sv | 36 +++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/csr_file.sv | 192 +++++++++++++++++++
 tb/tb_csr_file.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map, operation encodings and counter helper for csr_file.
package csr_pkg;

    typedef enum logic [11:0] {
        ADDR_MSTATUS  = 12'h300,
        ADDR_MIE      = 12'h304,
        ADDR_MTVEC    = 12'h305,
        ADDR_MEPC     = 12'h341,
        ADDR_MCAUSE   = 12'h342,
        ADDR_MIP      = 12'h344,
        ADDR_MCYCLE   = 12'hB00,
        ADDR_MINSTRET = 12'hB02,
        ADDR_MCYCLEH  = 12'hB80,
        ADDR_MINSTRETH = 12'hB82
    } csr_addr_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_t;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam logic [1:0]  MTVEC_MODE_VEC = 2'b01;

    // Counters are held in 64 bits; a narrow counter keeps its upper half at 0 so it wraps at 2^32.
    function automatic logic [63:0] cnt_inc(input logic [63:0] value, input bit wide);
        logic [63:0] result;
        result = value + 64'd1;
        if (!wide) result[63:32] = '0;
        return result;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt lines.
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         idx
);

    // Scan upward and keep the first set bit found.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause/mip plus mcycle/minstret.
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned NUM_IRQ  = 4,
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned VECTORED = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [11:0]        ADDR,
    input  logic [31:0]        WD,
    input  logic [1:0]         OP,
    input  logic               WR_EN,
    input  logic [31:0]        PC,
    input  logic               INT_TAKEN,
    input  logic               MRET,
    input  logic               INSTR_RET,
    output logic [31:0]        RD,
    output logic               INT_PEND,
    output logic [31:0]        TRAP_PC,
    output logic [31:0]        CSR_MEPC
);

    localparam bit HI_EN = (CNT_W > 32);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mie_q;
    logic               status_mie;
    logic               status_mpie;
    logic [31:2]        mtvec_base;
    logic [1:0]         mtvec_mode;
    logic [31:2]        mepc_q;
    logic               mcause_irq;
    logic [3:0]         mcause_code;
    logic [63:0]        mcycle;
    logic [63:0]        minstret;

    logic [NUM_IRQ-1:0] irq_act;
    logic               irq_valid;
    logic [3:0]         irq_idx;
    logic [31:0]        rd_val;
    logic [31:0]        new_val;
    logic [31:0]        trap_pc;
    csr_op_t            op;
    logic               wr_fire;
    logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
    logic               wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
    logic               unused_pc;

    assign unused_pc = ^PC[1:0];

    assign op      = csr_op_t'(OP);
    assign wr_fire = WR_EN && (op != OP_NONE);

    assign wr_mstatus   = wr_fire && (ADDR == ADDR_MSTATUS);
    assign wr_mie       = wr_fire && (ADDR == ADDR_MIE);
    assign wr_mtvec     = wr_fire && (ADDR == ADDR_MTVEC);
    assign wr_mepc      = wr_fire && (ADDR == ADDR_MEPC);
    assign wr_mcause    = wr_fire && (ADDR == ADDR_MCAUSE);
    assign wr_mcycle    = wr_fire && (ADDR == ADDR_MCYCLE);
    assign wr_mcycleh   = wr_fire && (ADDR == ADDR_MCYCLEH) && HI_EN;
    assign wr_minstret  = wr_fire && (ADDR == ADDR_MINSTRET);
    assign wr_minstreth = wr_fire && (ADDR == ADDR_MINSTRETH) && HI_EN;

    assign irq_act = irq_q & mie_q;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req   (irq_act),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign INT_PEND = status_mie & irq_valid;
    assign TRAP_PC  = trap_pc;
    assign CSR_MEPC = {mepc_q, 2'b00};
    assign RD       = rd_val;

    // Trap target: base, offset by 4*idx in vectored mode.
    always_comb begin
        trap_pc = {mtvec_base, 2'b00};
        if (mtvec_mode == MTVEC_MODE_VEC) trap_pc = trap_pc + {26'b0, irq_idx, 2'b00};
    end

    // Read mux; returns the value before any write this cycle.
    always_comb begin
        rd_val = '0;
        case (ADDR)
            ADDR_MSTATUS: begin
                rd_val[MSTATUS_MIE]  = status_mie;
                rd_val[MSTATUS_MPIE] = status_mpie;
            end
            ADDR_MIE:       rd_val[NUM_IRQ-1:0] = mie_q;
            ADDR_MTVEC:     rd_val = {mtvec_base, mtvec_mode};
            ADDR_MEPC:      rd_val = {mepc_q, 2'b00};
            ADDR_MCAUSE:    rd_val = {mcause_irq, 27'b0, mcause_code};
            ADDR_MIP:       rd_val[NUM_IRQ-1:0] = irq_q;
            ADDR_MCYCLE:    rd_val = mcycle[31:0];
            ADDR_MINSTRET:  rd_val = minstret[31:0];
            ADDR_MCYCLEH:   if (HI_EN) rd_val = mcycle[63:32];
            ADDR_MINSTRETH: if (HI_EN) rd_val = minstret[63:32];
            default:        rd_val = '0;
        endcase
    end

    // Read-modify-write operand for CSRRW/CSRRS/CSRRC.
    always_comb begin
        new_val = rd_val;
        case (op)
            OP_RW:   new_val = WD;
            OP_RS:   new_val = rd_val | WD;
            OP_RC:   new_val = rd_val & ~WD;
            default: new_val = rd_val;
        endcase
    end

    // Interrupt lines sampled once; mip reflects this register.
    always_ff @(posedge CLK) begin
        if (RST) irq_q <= '0;
        else     irq_q <= IRQ;
    end

    // mstatus: trap entry beats mret, mret beats a CSR write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
        end else if (INT_TAKEN) begin
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (MRET) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            status_mie  <= new_val[MSTATUS_MIE];
            status_mpie <= new_val[MSTATUS_MPIE];
        end
    end

    // mie and mtvec; illegal mtvec modes collapse to direct mode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mie_q      <= '0;
            mtvec_base <= '0;
            mtvec_mode <= '0;
        end else begin
            if (wr_mie) mie_q <= new_val[NUM_IRQ-1:0];
            if (wr_mtvec) begin
                mtvec_base <= new_val[31:2];
                mtvec_mode <= ((VECTORED != 0) && (new_val[1:0] == MTVEC_MODE_VEC))
                              ? MTVEC_MODE_VEC : 2'b00;
            end
        end
    end

    // mepc/mcause: trap entry overrides a CSR write in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mepc_q      <= '0;
            mcause_irq  <= 1'b0;
            mcause_code <= '0;
        end else if (INT_TAKEN) begin
            mepc_q      <= PC[31:2];
            mcause_irq  <= 1'b1;
            mcause_code <= INT_PEND ? irq_idx : 4'd0;
        end else begin
            if (wr_mepc) mepc_q <= new_val[31:2];
            if (wr_mcause) begin
                mcause_irq  <= new_val[31];
                mcause_code <= new_val[3:0];
            end
        end
    end

    // Free-running counters; a write to either half replaces that cycle's increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_mcycle)       mcycle[31:0]  <= new_val;
            else if (wr_mcycleh) mcycle[63:32] <= new_val;
            else                 mcycle        <= cnt_inc(mcycle, HI_EN);

            if (wr_minstret)       minstret[31:0]  <= new_val;
            else if (wr_minstreth) minstret[63:32] <= new_val;
            else if (INSTR_RET)    minstret        <= cnt_inc(minstret, HI_EN);
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed, table-driven bench for csr_file: one vectored 64-bit-counter instance
// and one direct-only 32-bit-counter instance share every input.
module tb_csr_file;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  IRQ;
    logic [11:0] ADDR;
    logic [31:0] WD;
    logic [1:0]  OP;
    logic        WR_EN;
    logic [31:0] PC;
    logic        INT_TAKEN;
    logic        MRET;
    logic        INSTR_RET;

    logic [31:0] rd, trap_pc, mepc;
    logic        int_pend;
    logic [31:0] nv_rd, nv_trap_pc, nv_mepc;
    logic        nv_int_pend;

    int n_chk = 0;
    int n_err = 0;

    always #10 CLK = ~CLK;

    csr_file #(.NUM_IRQ(4), .CNT_W(64), .VECTORED(1)) dut (
        .CLK(CLK), .RST(RST), .IRQ(IRQ), .ADDR(ADDR), .WD(WD), .OP(OP),
        .WR_EN(WR_EN), .PC(PC), .INT_TAKEN(INT_TAKEN), .MRET(MRET),
        .INSTR_RET(INSTR_RET), .RD(rd), .INT_PEND(int_pend),
        .TRAP_PC(trap_pc), .CSR_MEPC(mepc)
    );

    csr_file #(.NUM_IRQ(4), .CNT_W(32), .VECTORED(0)) dut_nv (
        .CLK(CLK), .RST(RST), .IRQ(IRQ), .ADDR(ADDR), .WD(WD), .OP(OP),
        .WR_EN(WR_EN), .PC(PC), .INT_TAKEN(INT_TAKEN), .MRET(MRET),
        .INSTR_RET(INSTR_RET), .RD(nv_rd), .INT_PEND(nv_int_pend),
        .TRAP_PC(nv_trap_pc), .CSR_MEPC(nv_mepc)
    );

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic        en;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] exp_nv;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Combinational read of one address on both instances.
    task automatic rd2(input string name, input logic [11:0] a,
                       input logic [31:0] exp, input logic [31:0] exp_nv);
        ADDR = a;
        #1;
        check(name, rd, exp);
        check({name, "_nv"}, nv_rd, exp_nv);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
        ADDR = a; OP = o; WD = d; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0; OP = 2'b00; WD = '0;
    endtask

    initial begin
        vecs[0]  = '{12'h304, 2'b01, 1'b1, 32'h0000_000F, 32'h0,         32'h0};
        vecs[1]  = '{12'h304, 2'b10, 1'b1, 32'h0000_0010, 32'hF,         32'hF};
        vecs[2]  = '{12'h304, 2'b11, 1'b1, 32'h0000_0003, 32'hF,         32'hF};
        vecs[3]  = '{12'h304, 2'b00, 1'b1, 32'h0000_0000, 32'hC,         32'hC};
        vecs[4]  = '{12'h304, 2'b01, 1'b0, 32'h0000_0006, 32'hC,         32'hC};
        vecs[5]  = '{12'h304, 2'b01, 1'b1, 32'h0000_0006, 32'hC,         32'hC};
        vecs[6]  = '{12'h304, 2'b00, 1'b0, 32'h0000_0000, 32'h6,         32'h6};
        vecs[7]  = '{12'h305, 2'b01, 1'b1, 32'h0000_0101, 32'h0,         32'h0};
        vecs[8]  = '{12'h305, 2'b01, 1'b1, 32'h0000_0103, 32'h101,       32'h100};
        vecs[9]  = '{12'h305, 2'b00, 1'b0, 32'h0000_0000, 32'h100,       32'h100};
        vecs[10] = '{12'h305, 2'b01, 1'b1, 32'h0000_0101, 32'h100,       32'h100};
        vecs[11] = '{12'h305, 2'b00, 1'b0, 32'h0000_0000, 32'h101,       32'h100};
        vecs[12] = '{12'h300, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[13] = '{12'h300, 2'b11, 1'b1, 32'h0000_0080, 32'h88,        32'h88};
        vecs[14] = '{12'h300, 2'b00, 1'b0, 32'h0000_0000, 32'h8,         32'h8};
        vecs[15] = '{12'h341, 2'b01, 1'b1, 32'h0000_0203, 32'h0,         32'h0};
        vecs[16] = '{12'h341, 2'b00, 1'b0, 32'h0000_0000, 32'h200,       32'h200};
        vecs[17] = '{12'h342, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[18] = '{12'h342, 2'b00, 1'b0, 32'h0000_0000, 32'h8000_000F, 32'h8000_000F};
        vecs[19] = '{12'h7C0, 2'b01, 1'b1, 32'h0000_FFFF, 32'h0,         32'h0};
        vecs[20] = '{12'h7C0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0};
        vecs[21] = '{12'h344, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0};

        RST = 1'b1; IRQ = '0; ADDR = '0; WD = '0; OP = 2'b00; WR_EN = 1'b0;
        PC = '0; INT_TAKEN = 1'b0; MRET = 1'b0; INSTR_RET = 1'b0;
        tick();
        tick();
        RST = 1'b0;

        // First cycle after reset.
        check("int_pend_rst", {31'b0, int_pend}, 32'h0);
        check("trap_pc_rst", trap_pc, 32'h0);
        rd2("mstatus_rst", 12'h300, 32'h0, 32'h0);
        rd2("mtvec_rst", 12'h305, 32'h0, 32'h0);
        rd2("mepc_rst", 12'h341, 32'h0, 32'h0);
        rd2("mcycle_rst", 12'hB00, 32'h0, 32'h0);

        INSTR_RET = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        INSTR_RET = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rd2("mcycle_10", 12'hB00, 32'd10, 32'd10);
        rd2("minstret_3", 12'hB02, 32'd3, 32'd3);
        rd2("minstreth_0", 12'hB82, 32'd0, 32'd0);

        // Register map and read-modify-write table.
        for (int i = 0; i < 22; i++) begin
            ADDR = vecs[i].addr; OP = vecs[i].op; WD = vecs[i].wd; WR_EN = vecs[i].en;
            #1;
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
            check($sformatf("vec%0d_rd_nv", i), nv_rd, vecs[i].exp_nv);
            tick();
            WR_EN = 1'b0; OP = 2'b00; WD = '0;
        end

        // Interrupt entry: mie=0x6, MIE=1, mtvec=0x101 (vectored) / 0x100 (direct).
        IRQ = 4'b0110;
        #1;
        check("int_pend_before_sync", {31'b0, int_pend}, 32'h0);
        tick();
        check("int_pend_after_sync", {31'b0, int_pend}, 32'h1);
        check("trap_pc_vec", trap_pc, 32'h104);
        check("trap_pc_direct", nv_trap_pc, 32'h100);
        rd2("mip", 12'h344, 32'h6, 32'h6);

        INT_TAKEN = 1'b1; PC = 32'h200;
        csr_write(12'h300, 2'b01, 32'h8);
        INT_TAKEN = 1'b0;
        check("int_pend_after_take", {31'b0, int_pend}, 32'h0);
        check("csr_mepc_take", mepc, 32'h200);
        rd2("mepc_take", 12'h341, 32'h200, 32'h200);
        rd2("mcause_take", 12'h342, 32'h8000_0001, 32'h8000_0001);
        rd2("mstatus_take", 12'h300, 32'h80, 32'h80);

        // MRET beats a same-cycle mstatus write.
        MRET = 1'b1;
        csr_write(12'h300, 2'b01, 32'h0);
        MRET = 1'b0;
        rd2("mstatus_mret", 12'h300, 32'h88, 32'h88);
        check("int_pend_mret", {31'b0, int_pend}, 32'h1);

        // INT_TAKEN beats MRET.
        INT_TAKEN = 1'b1; MRET = 1'b1; PC = 32'h300;
        tick();
        INT_TAKEN = 1'b0; MRET = 1'b0;
        rd2("mstatus_take_mret", 12'h300, 32'h80, 32'h80);
        rd2("mcause_take_mret", 12'h342, 32'h8000_0001, 32'h8000_0001);
        check("csr_mepc_take_mret", mepc, 32'h300);

        // INT_TAKEN with nothing pending, plus a losing mepc write.
        check("int_pend_idle", {31'b0, int_pend}, 32'h0);
        INT_TAKEN = 1'b1; PC = 32'h307;
        csr_write(12'h341, 2'b01, 32'hABC);
        INT_TAKEN = 1'b0;
        rd2("mepc_nopend", 12'h341, 32'h304, 32'h304);
        rd2("mcause_nopend", 12'h342, 32'h8000_0000, 32'h8000_0000);
        rd2("mstatus_nopend", 12'h300, 32'h0, 32'h0);

        // Counter half writes and carry.
        csr_write(12'hB80, 2'b01, 32'h0);
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        rd2("mcycle_lo_set", 12'hB00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd2("mcycle_hi_set", 12'hB80, 32'h0, 32'h0);
        tick();
        rd2("mcycle_lo_wrap", 12'hB00, 32'h0, 32'h0);
        rd2("mcycle_hi_carry", 12'hB80, 32'h1, 32'h0);
        csr_write(12'hB80, 2'b01, 32'h5);
        rd2("mcycle_lo_hold", 12'hB00, 32'h0, 32'h1);
        rd2("mcycle_hi_wr", 12'hB80, 32'h5, 32'h0);
        tick();
        rd2("mcycle_lo_resume", 12'hB00, 32'h1, 32'h2);

        // Reset asserted together with a trap.
        csr_write(12'h300, 2'b01, 32'h8);
        RST = 1'b1; INT_TAKEN = 1'b1; PC = 32'h400;
        tick();
        RST = 1'b0; INT_TAKEN = 1'b0;
        check("int_pend_rst2", {31'b0, int_pend}, 32'h0);
        check("csr_mepc_rst2", mepc, 32'h0);
        rd2("mstatus_rst2", 12'h300, 32'h0, 32'h0);
        rd2("mcause_rst2", 12'h342, 32'h0, 32'h0);
        rd2("mie_rst2", 12'h304, 32'h0, 32'h0);
        rd2("mcycle_rst2", 12'hB00, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
